// File: rtl/aes_inv_key_sched.sv
// ---------------------------------------------------------------------------
// aes_sbox
//   Combinational AES forward S-box, implemented as a 256-entry lookup table.
//   Ports:
//     a_i  in  8  input byte
//     s_o  out 8  substituted byte
// ---------------------------------------------------------------------------
// aes_inv_key_sched
//   AES-128 key schedule delivered in decryption order. The cipher key is
//   expanded forward to the round-10 key. The schedule is then walked backwards,
//   and one round key (10 down to 0) is presented per valid/ready handshake.
//   Only a single 128-bit key register is kept.
//   Ports:
//     clk       in  1    rising-edge clock
//     rst_n     in  1    asynchronous active-low reset
//     start     in  1    load key_in and begin (honoured only when idle)
//     key_in    in  128  cipher key, word0 = [127:96]
//     busy      out 1    expanding or presenting keys
//     rk_valid  out 1    rk_data/rk_round hold a valid round key
//     rk_ready  in  1    consumer accepts the key on rk_valid & rk_ready
//     rk_data   out 128  current round key, word0 = [127:96]
//     rk_round  out 4    round index of rk_data
//     done      out 1    one-cycle pulse after the round-0 key is accepted
// ---------------------------------------------------------------------------

module aes_sbox (
  input  logic [7:0] a_i,
  output logic [7:0] s_o
);

  // Entry 0 occupies the most significant byte of the table.
  localparam logic [0:2047] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign s_o = SBOX_TABLE[{a_i, 3'b000} +: 8];

endmodule

module aes_inv_key_sched #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_data,
  output logic [3:0]   rk_round,
  output logic         done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    OUT  = 2'd2
  } state_e;

  state_e       state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [3:0]   rnd_q, rnd_d;
  logic         done_q, done_d;

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] subIn, rotWord, subWord, t;
  logic [3:0]  rconIdx;
  logic [7:0]  rcon;
  logic [31:0] f0, f1, f2, f3;
  logic [31:0] p0, p1, p2, p3;
  logic        handshake;

  assign w0 = key_q[127:96];
  assign w1 = key_q[95:64];
  assign w2 = key_q[63:32];
  assign w3 = key_q[31:0];

  // The backward step recovers the previous w3 as w3^w2 and substitutes that,
  // so one set of S-boxes serves both directions through this input mux.
  assign subIn   = (state_q == OUT) ? (w3 ^ w2) : w3;
  assign rotWord = {subIn[23:0], subIn[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    aes_sbox u_sbox (
      .a_i (rotWord[8*i +: 8]),
      .s_o (subWord[8*i +: 8])
    );
  end

  // Forward step i produces round i+1 and needs Rcon(i+1); the backward step
  // from round i needs Rcon(i). Rcon(0) is therefore never selected.
  assign rconIdx = (state_q == OUT) ? rnd_q : 4'(rnd_q + 4'd1);

  always_comb begin
    rcon = 8'h00;
    case (rconIdx)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  assign t = subWord ^ {rcon, 24'h000000};

  assign f0 = w0 ^ t;
  assign f1 = w1 ^ f0;
  assign f2 = w2 ^ f1;
  assign f3 = w3 ^ f2;

  assign p3 = w3 ^ w2;
  assign p2 = w2 ^ w1;
  assign p1 = w1 ^ w0;
  assign p0 = w0 ^ t;

  assign handshake = (state_q == OUT) && rk_ready;

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    rnd_d   = rnd_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          key_d   = key_in;
          rnd_d   = 4'd0;
          state_d = FWD;
        end
      end
      FWD: begin
        key_d = {f0, f1, f2, f3};
        rnd_d = 4'(rnd_q + 4'd1);
        if (rnd_q == 4'(NR - 1)) begin
          state_d = OUT;
        end
      end
      OUT: begin
        if (handshake) begin
          if (rnd_q == 4'd0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            key_d = {p0, p1, p2, p3};
            rnd_d = 4'(rnd_q - 4'd1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      key_q   <= '0;
      rnd_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      rnd_q   <= rnd_d;
      done_q  <= done_d;
    end
  end

  // Key outputs are forced to zero outside OUT so that the consumer never
  // sees intermediate forward-expansion values.
  assign busy     = (state_q != IDLE);
  assign rk_valid = (state_q == OUT);
  assign rk_data  = rk_valid ? key_q : '0;
  assign rk_round = rk_valid ? rnd_q : '0;
  assign done     = done_q;

endmodule

// File: tb/tb_aes_inv_key_sched.sv
// ---------------------------------------------------------------------------
// tb_aes_inv_key_sched
//   Self-checking bench for aes_inv_key_sched. A reference key expansion built
//   from a GF(2^8)-derived S-box fills a scoreboard queue when a key is
//   started, and entries are popped and compared on every round-key handshake.
// ---------------------------------------------------------------------------

module tb_aes_inv_key_sched;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [127:0] key_in;
  logic         busy;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] rk_data;
  logic [3:0]   rk_round;
  logic         done;

  aes_inv_key_sched #(.NR(10)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .key_in   (key_in),
    .busy     (busy),
    .rk_valid (rk_valid),
    .rk_ready (rk_ready),
    .rk_data  (rk_data),
    .rk_round (rk_round),
    .done     (done)
  );

  typedef struct packed {
    logic [3:0]   round;
    logic [127:0] data;
  } sbEntry_t;

  sbEntry_t     sbQ[$];
  logic [7:0]   sboxRef[256];
  logic [127:0] expRk[11];
  int           checks;
  int           failures;
  int           doneCount;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts every cycle in which done is high, sampled away from the edge.
  always @(negedge clk) begin
    if (done === 1'b1) doneCount++;
  end

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // S-box from the multiplicative inverse followed by the affine transform.
  task automatic buildSbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      sboxRef[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                   ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subWordRef(input logic [31:0] w);
    return {sboxRef[w[31:24]], sboxRef[w[23:16]], sboxRef[w[15:8]], sboxRef[w[7:0]]};
  endfunction

  task automatic computeModel(input logic [127:0] key);
    logic [31:0] a0, a1, a2, a3, tt;
    logic [7:0]  rc;
    expRk[0] = key;
    rc = 8'h01;
    for (int r = 1; r <= 10; r++) begin
      a0 = expRk[r-1][127:96];
      a1 = expRk[r-1][95:64];
      a2 = expRk[r-1][63:32];
      a3 = expRk[r-1][31:0];
      tt = subWordRef({a3[23:0], a3[31:24]}) ^ {rc, 24'h000000};
      a0 = a0 ^ tt;
      a1 = a1 ^ a0;
      a2 = a2 ^ a1;
      a3 = a3 ^ a2;
      expRk[r] = {a0, a1, a2, a3};
      rc = gmul(rc, 8'h02);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] obs,
                             input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Runs one key through the DUT. mode 0 keeps rk_ready high, mode 1 toggles
  // it randomly. glitch pulses start with a foreign key while busy. stopAt>=0
  // asserts reset asynchronously once that round is presented.
  task automatic applyStimulus(input logic [127:0] key, input int mode,
                               input bit glitch, input int stopAt);
    sbEntry_t     e;
    bit           stalled;
    logic [127:0] heldData;
    logic [3:0]   heldRound;
    int           accepted;
    int           iter;
    int           doneBefore;
    bit           finished;
    bit           ready;

    @(negedge clk);
    checkOutput("idle_busy", busy, 1'b0);
    checkOutput("idle_valid", rk_valid, 1'b0);
    key_in = key;
    start  = 1'b1;
    for (int r = 10; r >= 0; r--) begin
      e.round = 4'(r);
      e.data  = expRk[r];
      sbQ.push_back(e);
    end
    doneBefore = doneCount;

    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      if (k == 0) begin
        start  = 1'b0;
        key_in = {$urandom, $urandom, $urandom, $urandom};
      end
      if (glitch && k == 4) start = 1'b1;
      if (glitch && k == 5) start = 1'b0;
      checkOutput($sformatf("lat_valid_k%0d", k), rk_valid, (k == 10));
      checkOutput($sformatf("lat_busy_k%0d", k), busy, 1'b1);
    end

    stalled  = 1'b0;
    accepted = 0;
    iter     = 0;
    finished = 1'b0;
    while (!finished && iter < 300) begin
      if (stalled) begin
        checkOutput("stall_valid", rk_valid, 1'b1);
        checkOutput("stall_round", rk_round, heldRound);
        checkOutput("stall_data", rk_data, heldData);
      end
      if (stopAt >= 0 && rk_valid === 1'b1 && rk_round == 4'(stopAt)) begin
        rk_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_valid", rk_valid, 1'b0);
        checkOutput("rst_data", rk_data, 128'h0);
        checkOutput("rst_round", rk_round, 4'h0);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_done", done, 1'b0);
        sbQ.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        checkOutput("rst_no_done", doneCount, doneBefore);
        return;
      end
      ready = (mode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
      rk_ready = ready;
      start = glitch && (iter == 3);
      if (glitch && iter == 3) key_in = ~key;
      if (rk_valid === 1'b1 && ready) begin
        stalled = 1'b0;
        if (sbQ.size() == 0) begin
          checkOutput("sb_underflow", 1'b1, 1'b0);
          finished = 1'b1;
        end else begin
          e = sbQ.pop_front();
          checkOutput($sformatf("rk_round_%0d", e.round), rk_round, e.round);
          checkOutput($sformatf("rk_data_%0d", e.round), rk_data, e.data);
          accepted++;
          if (e.round == 4'd0) finished = 1'b1;
        end
      end else if (rk_valid === 1'b1) begin
        stalled   = 1'b1;
        heldData  = rk_data;
        heldRound = rk_round;
      end
      iter++;
      @(negedge clk);
    end
    start = 1'b0;
    checkOutput("drain_timeout", finished, 1'b1);
    if (mode == 0) checkOutput("full_throughput", iter, 11);
    checkOutput("accepted", accepted, 11);
    checkOutput("done_pulse", done, 1'b1);
    checkOutput("done_busy", busy, 1'b0);
    checkOutput("done_valid", rk_valid, 1'b0);
    rk_ready = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("done_single", done, 1'b0);
    checkOutput("done_count", doneCount - doneBefore, 1);
    checkOutput("sb_empty", sbQ.size(), 0);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    doneCount = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    key_in    = '0;
    rk_ready  = 1'b0;
    buildSbox();
    #3;
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_valid", rk_valid, 1'b0);
    checkOutput("reset_data", rk_data, 128'h0);
    checkOutput("reset_round", rk_round, 4'h0);
    checkOutput("reset_done", done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] FIPS-197 key, full throughput");
    computeModel(FIPS_KEY);
    expRk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    expRk[9]  = 128'hac7766f319fadc2128d12941575c006e;
    expRk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    expRk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    applyStimulus(FIPS_KEY, 0, 1'b0, -1);

    $display("[TB] all-zero key");
    computeModel(128'h0);
    expRk[10] = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
    expRk[0]  = 128'h0;
    applyStimulus(128'h0, 0, 1'b0, -1);

    $display("[TB] FIPS-197 key, random rk_ready");
    computeModel(FIPS_KEY);
    applyStimulus(FIPS_KEY, 1, 1'b0, -1);

    $display("[TB] start pulses while busy are ignored");
    applyStimulus(FIPS_KEY, 1, 1'b1, -1);

    $display("[TB] reset at round 5, then full restart");
    applyStimulus(FIPS_KEY, 0, 1'b0, 5);
    applyStimulus(FIPS_KEY, 0, 1'b0, -1);

    $display("[TB] random key");
    key_in = {$urandom, $urandom, $urandom, $urandom};
    computeModel(key_in);
    applyStimulus(key_in, 1, 1'b0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
